prv_trap_sequencer: RTL and testbench
=====================================

Name: prv_trap_sequencer

Overview:
- Parametrised trap-entry and return sequencer between pipeline hazard unit and machine-mode CSR block.
- Replaces fixed timer/soft/ext interrupt wires with NUM_INT_SRC configurable sources, each level- or edge-triggered.
- Prioritises exceptions over interrupts, waits for pipeline drain, commits cause/epc/tval to CSRs, then redirects fetch (direct or vectored mtvec).
- Also sequences mret redirects.

Parameters:
- XLEN, 32, datapath/address width.
- NUM_EXC_SRC, 16, exception request bits; bit i = cause code i.
- NUM_INT_SRC, 12, interrupt sources; source i = interrupt cause code i (matches mip layout).
- INT_EDGE_MASK, 0, NUM_INT_SRC-bit; bit i=1 makes source i edge-triggered and latched.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- exc_vec  in  NUM_EXC_SRC  exception requests from hazard unit
- exc_badaddr  in  XLEN  faulting address/instruction for tval
- epc  in  XLEN  PC of the excepting/interrupted instruction
- int_req  in  NUM_INT_SRC  raw interrupt requests
- int_en  in  NUM_INT_SRC  mie enables
- global_ie  in  1  mstatus.MIE
- mtvec  in  XLEN  BASE[XLEN-1:2], MODE[1:0]
- mepc  in  XLEN  return target for mret
- ret  in  1  mret retiring
- pipe_clear  in  1  pipeline drained
- int_pend  out  NUM_INT_SRC  effective pending vector (mip view)
- trap_valid  out  1  one-cycle CSR commit strobe
- trap_cause  out  XLEN  MSB=interrupt flag, low bits=code
- trap_epc  out  XLEN  captured epc
- trap_tval  out  XLEN  captured tval
- int_ack  out  NUM_INT_SRC  one-hot pulse clearing a taken edge latch
- insert_pc  out  1  redirect fetch this cycle
- priv_pc  out  XLEN  redirect target
- busy  out  1  state != IDLE

Behaviour:
- Async reset: state IDLE; all outputs, capture registers, edge latches and int_req sample registers = 0.
- Reset asserted mid-sequence aborts it; no trap_valid/insert_pc.
- Pending: level source i: int_pend[i]=int_req[i].
- Edge source i: latch sets on int_req 0->1 (registered previous sample); clears on int_ack[i].
- Edge set and ack for the same bit in the same cycle: set wins.
- Eligible interrupt: global_ie & |(int_pend & int_en).
- Exception priority: lowest set index of exc_vec.
- Interrupt priority: highest set index of (int_pend & int_en).
- Exceptions beat interrupts; any trap beats ret in the same cycle.
- IDLE: on exception, capture cause={0,code}, epc, tval=exc_badaddr, go DRAIN.
- IDLE: else on eligible interrupt, capture cause={1,code}, epc, tval=0, go DRAIN.
- IDLE: else on ret, go RET.
- DRAIN: wait for pipe_clear=1, then go COMMIT. New requests ignored while busy.
- COMMIT: trap_valid=1 for one cycle; trap_cause/epc/tval valid that cycle and held until next capture. If interrupt, int_ack[code]=1 for this cycle only. Go REDIRECT.
- REDIRECT: insert_pc=1 for one cycle, then go IDLE.
- REDIRECT target: priv_pc = {BASE,2'b00}, or {BASE,2'b00}+4*code when MODE=1 and interrupt. MODE 2/3 treated as direct. Address add wraps mod 2^XLEN.
- RET: insert_pc=1, priv_pc=mepc for one cycle, then go IDLE.
- Latency: request sampled in cycle n with pipe_clear already 1 -> trap_valid n+2, insert_pc n+3.
- Latency: ret in cycle n -> insert_pc n+1.
- insert_pc and trap_valid never asserted together. priv_pc = 0 when insert_pc = 0.

Test Plan:
- Reset, then exc_vec=0x0004, epc=0x100, exc_badaddr=0xDEAD, pipe_clear=1, mtvec=0x8000_0001 -> trap_valid at n+2 with cause=0x2, epc=0x100, tval=0xDEAD; insert_pc at n+3, priv_pc=0x8000_0000.
- int_req[7]=1 level, int_en[7]=1, global_ie=1, mtvec=0x8000_0001 -> cause=0x8000_0007, tval=0, priv_pc=0x8000_001C; int_ack[7] pulses in the COMMIT cycle.
- Same cycle: exc_vec=0x0008 and int_req[11] eligible -> exception cause 0x3 taken; interrupt taken in a later sequence after return to IDLE.
- Edge source 3 (INT_EDGE_MASK=0x008): pulse int_req[3] for one cycle while global_ie=0 -> int_pend[3] stays 1. Set global_ie=1 -> trap taken, int_ack[3] pulses, int_pend[3]=0. Repeat with a new rising edge in the ack cycle -> int_pend[3] remains 1.
- Hold pipe_clear=0 for 5 cycles after an exception -> busy=1, no trap_valid; trap_valid one cycle after pipe_clear rises. Assert nRST=0 during DRAIN -> all outputs 0, no insert_pc.
- ret=1, mepc=0x0000_0400 in IDLE -> insert_pc=1, priv_pc=0x400 next cycle. ret with simultaneous exc_vec=0x0001 -> trap taken, ret ignored.

Source files
------------

// File: rtl/prv_trap_sequencer.sv
// Trap-entry / mret sequencer between the hazard unit and the M-mode CSRs.
// Prioritises exceptions, waits for drain, commits cause/epc/tval, redirects.
module prv_trap_sequencer #(
  parameter int XLEN        = 32,
  parameter int NUM_EXC_SRC = 16,
  parameter int NUM_INT_SRC = 12,
  parameter logic [NUM_INT_SRC-1:0] INT_EDGE_MASK = '0
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NUM_EXC_SRC-1:0] exc_vec,
  input  logic [XLEN-1:0]        exc_badaddr,
  input  logic [XLEN-1:0]        epc,
  input  logic [NUM_INT_SRC-1:0] int_req,
  input  logic [NUM_INT_SRC-1:0] int_en,
  input  logic                   global_ie,
  input  logic [XLEN-1:0]        mtvec,
  input  logic [XLEN-1:0]        mepc,
  input  logic                   ret,
  input  logic                   pipe_clear,
  output logic [NUM_INT_SRC-1:0] int_pend,
  output logic                   trap_valid,
  output logic [XLEN-1:0]        trap_cause,
  output logic [XLEN-1:0]        trap_epc,
  output logic [XLEN-1:0]        trap_tval,
  output logic [NUM_INT_SRC-1:0] int_ack,
  output logic                   insert_pc,
  output logic [XLEN-1:0]        priv_pc,
  output logic                   busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRAIN  = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_REDIR  = 3'd3;
  localparam logic [2:0] S_RET    = 3'd4;

  logic [2:0]             r_state;
  logic [NUM_INT_SRC-1:0] r_int_prev;
  logic [NUM_INT_SRC-1:0] r_edge_lat;
  logic [XLEN-1:0]        r_cause;
  logic [XLEN-1:0]        r_epc;
  logic [XLEN-1:0]        r_tval;

  logic [NUM_INT_SRC-1:0] w_elig;
  logic [NUM_INT_SRC-1:0] w_ack;
  logic [XLEN-2:0]        w_exc_code;
  logic [XLEN-2:0]        w_int_code;
  logic                   w_exc_any;
  logic                   w_int_any;
  logic                   w_is_int;
  logic [XLEN-1:0]        w_base;
  logic [XLEN-1:0]        w_vec_off;

  assign int_pend  = (INT_EDGE_MASK & r_edge_lat)
                   | (~INT_EDGE_MASK & int_req);
  assign w_elig    = int_pend & int_en;
  assign w_exc_any = |exc_vec;
  assign w_int_any = global_ie & (|w_elig);
  assign w_is_int  = r_cause[XLEN-1];

  // Lowest exception index wins: scan downwards, last hit sticks.
  always_comb begin
    w_exc_code = '0;
    for (int i = NUM_EXC_SRC - 1; i >= 0; i--) begin
      if (exc_vec[i]) w_exc_code = (XLEN-1)'(i);
    end
  end

  // Highest interrupt index wins: scan upwards.
  always_comb begin
    w_int_code = '0;
    for (int i = 0; i < NUM_INT_SRC; i++) begin
      if (w_elig[i]) w_int_code = (XLEN-1)'(i);
    end
  end

  always_comb begin
    w_ack = '0;
    if (r_state == S_COMMIT && w_is_int) begin
      for (int i = 0; i < NUM_INT_SRC; i++) begin
        if (r_cause[XLEN-2:0] == (XLEN-1)'(i)) w_ack[i] = 1'b1;
      end
    end
  end

  assign int_ack = w_ack;

  // A new rising edge in the ack cycle re-arms the latch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_int_prev <= '0;
      r_edge_lat <= '0;
    end else begin
      r_int_prev <= int_req;
      r_edge_lat <= INT_EDGE_MASK
                  & ((r_edge_lat & ~w_ack) | (int_req & ~r_int_prev));
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cause <= '0;
      r_epc   <= '0;
      r_tval  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_exc_any) begin
            r_cause <= {1'b0, w_exc_code};
            r_epc   <= epc;
            r_tval  <= exc_badaddr;
            r_state <= S_DRAIN;
          end else if (w_int_any) begin
            r_cause <= {1'b1, w_int_code};
            r_epc   <= epc;
            r_tval  <= '0;
            r_state <= S_DRAIN;
          end else if (ret) begin
            r_state <= S_RET;
          end
        end
        S_DRAIN: begin
          if (pipe_clear) r_state <= S_COMMIT;
        end
        S_COMMIT: r_state <= S_REDIR;
        S_REDIR:  r_state <= S_IDLE;
        S_RET:    r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign trap_valid = (r_state == S_COMMIT);
  assign insert_pc  = (r_state == S_REDIR) | (r_state == S_RET);
  assign busy       = (r_state != S_IDLE);
  assign trap_cause = r_cause;
  assign trap_epc   = r_epc;
  assign trap_tval  = r_tval;

  assign w_base    = {mtvec[XLEN-1:2], 2'b00};
  assign w_vec_off = {r_cause[XLEN-3:0], 2'b00};

  // MODE 2/3 fall back to direct.
  always_comb begin
    priv_pc = '0;
    if (r_state == S_REDIR) begin
      if (mtvec[1:0] == 2'b01 && w_is_int) priv_pc = w_base + w_vec_off;
      else                                priv_pc = w_base;
    end else if (r_state == S_RET) begin
      priv_pc = mepc;
    end
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Bench for prv_trap_sequencer: vector table, corner sequences,
// then random stimulus against a cycle-level reference model.
module tb_prv_trap_sequencer;

  localparam int XLEN = 32;
  localparam int NE   = 16;
  localparam int NI   = 12;
  localparam logic [NI-1:0] EM = 12'h008;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [NE-1:0]   exc_vec;
  logic [XLEN-1:0] exc_badaddr, epc, mtvec, mepc;
  logic [NI-1:0]   int_req, int_en;
  logic            global_ie, ret, pipe_clear;
  logic [NI-1:0]   int_pend, int_ack;
  logic            trap_valid, insert_pc, busy;
  logic [XLEN-1:0] trap_cause, trap_epc, trap_tval, priv_pc;

  prv_trap_sequencer #(
    .XLEN(XLEN), .NUM_EXC_SRC(NE), .NUM_INT_SRC(NI),
    .INT_EDGE_MASK(EM)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .exc_vec(exc_vec), .exc_badaddr(exc_badaddr), .epc(epc),
    .int_req(int_req), .int_en(int_en), .global_ie(global_ie),
    .mtvec(mtvec), .mepc(mepc), .ret(ret), .pipe_clear(pipe_clear),
    .int_pend(int_pend), .trap_valid(trap_valid),
    .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_tval(trap_tval), .int_ack(int_ack),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [NE-1:0]   exc;
    logic [31:0]     bad, ep;
    logic [NI-1:0]   ireq, ien;
    logic            gie;
    logic [31:0]     mtv, mep;
    logic            rt;
    int              kind;  // 0 nothing, 1 trap, 2 mret
    logic [31:0]     cause, tval, pc;
    logic [NI-1:0]   ack;
  } vec_t;

  vec_t tbl[11];

  // reference model state
  logic [NI-1:0] m_prev, m_lat;
  logic [31:0]   m_cause, m_epc, m_tval;
  bit            m_act, m_drain, m_ret;
  int            m_tv, m_ins, cyc;

  function automatic logic [154:0] outs_now();
    return {int_pend, trap_valid, trap_cause, trap_epc, trap_tval,
            int_ack, insert_pc, priv_pc, busy};
  endfunction

  initial begin
    tbl[0]  = '{16'h0004, 32'hDEAD, 32'h100, 12'h000, 12'h000, 1'b0,
                32'h8000_0001, 32'h0, 1'b0, 1,
                32'h2, 32'hDEAD, 32'h8000_0000, 12'h000};
    tbl[1]  = '{16'h0000, 32'h55, 32'h204, 12'h080, 12'h080, 1'b1,
                32'h8000_0001, 32'h0, 1'b0, 1,
                32'h8000_0007, 32'h0, 32'h8000_001C, 12'h080};
    tbl[2]  = '{16'h0008, 32'h1234, 32'h300, 12'h800, 12'h800, 1'b1,
                32'h8000_0001, 32'h0, 1'b0, 1,
                32'h3, 32'h1234, 32'h8000_0000, 12'h000};
    tbl[3]  = '{16'h8010, 32'hBEEF, 32'h404, 12'h000, 12'h000, 1'b0,
                32'h0000_1002, 32'h0, 1'b0, 1,
                32'h4, 32'hBEEF, 32'h0000_1000, 12'h000};
    tbl[4]  = '{16'h0000, 32'h77, 32'h500, 12'h0A0, 12'h020, 1'b1,
                32'h2000_0003, 32'h0, 1'b0, 1,
                32'h8000_0005, 32'h0, 32'h2000_0000, 12'h020};
    tbl[5]  = '{16'h0000, 32'h0, 32'h600, 12'hC00, 12'hFFF, 1'b1,
                32'hFFFF_FFFD, 32'h0, 1'b0, 1,
                32'h8000_000B, 32'h0, 32'h0000_0028, 12'h800};
    tbl[6]  = '{16'h0000, 32'h0, 32'h0, 12'h000, 12'h000, 1'b0,
                32'h0, 32'h400, 1'b1, 2,
                32'h0, 32'h0, 32'h400, 12'h000};
    tbl[7]  = '{16'h0001, 32'hAA, 32'h700, 12'h000, 12'h000, 1'b0,
                32'h100, 32'h400, 1'b1, 1,
                32'h0, 32'hAA, 32'h100, 12'h000};
    tbl[8]  = '{16'h0000, 32'h0, 32'h0, 12'h002, 12'h002, 1'b0,
                32'h0, 32'h0, 1'b0, 0,
                32'h0, 32'h0, 32'h0, 12'h000};
    tbl[9]  = '{16'h0000, 32'h0, 32'h0, 12'h010, 12'h000, 1'b1,
                32'h0, 32'h0, 1'b0, 0,
                32'h0, 32'h0, 32'h0, 12'h000};
    tbl[10] = '{16'h0000, 32'h9, 32'h800, 12'h001, 12'h001, 1'b1,
                32'h201, 32'h0, 1'b0, 1,
                32'h8000_0000, 32'h0, 32'h200, 12'h001};

    nRST = 1'b0;
    exc_vec = '0; exc_badaddr = '0; epc = '0;
    int_req = '0; int_en = '0; global_ie = 1'b0;
    mtvec = '0; mepc = '0; ret = 1'b0; pipe_clear = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outs", 160'(outs_now()), 160'd0);
    chk("reset_busy", 160'(busy), 160'd0);
    nRST = 1'b1;
    step();

    // ---------------- vector table ----------------
    for (int i = 0; i < 11; i++) begin
      exc_vec = tbl[i].exc; exc_badaddr = tbl[i].bad;
      epc = tbl[i].ep; int_req = tbl[i].ireq; int_en = tbl[i].ien;
      global_ie = tbl[i].gie; mtvec = tbl[i].mtv; mepc = tbl[i].mep;
      ret = tbl[i].rt; pipe_clear = 1'b1;
      #1;
      chk($sformatf("v%0d_idle", i), 160'(busy), 160'd0);
      step();
      exc_vec = '0; int_req = '0; ret = 1'b0; global_ie = 1'b0;
      #1;
      if (tbl[i].kind == 2) begin
        chk($sformatf("v%0d_ret", i),
            160'({insert_pc, trap_valid, priv_pc}),
            160'({1'b1, 1'b0, tbl[i].pc}));
        step();
        chk($sformatf("v%0d_done", i), 160'({busy, insert_pc}), 160'd0);
      end else if (tbl[i].kind == 1) begin
        chk($sformatf("v%0d_drain", i),
            160'({busy, trap_valid}), 160'(2'b10));
        step();
        chk($sformatf("v%0d_commit", i),
            160'({trap_valid, insert_pc, trap_cause, trap_epc,
                  trap_tval, int_ack}),
            160'({1'b1, 1'b0, tbl[i].cause, tbl[i].ep,
                  tbl[i].tval, tbl[i].ack}));
        step();
        chk($sformatf("v%0d_redir", i),
            160'({insert_pc, trap_valid, int_ack, priv_pc}),
            160'({1'b1, 1'b0, 12'h000, tbl[i].pc}));
        step();
        chk($sformatf("v%0d_done", i),
            160'({busy, insert_pc, priv_pc}), 160'd0);
      end else begin
        chk($sformatf("v%0d_none", i),
            160'({busy, insert_pc, trap_valid}), 160'd0);
      end
    end

    // ------- exception beats interrupt, interrupt taken later -------
    mtvec = 32'h8000_0001; epc = 32'h900; exc_badaddr = 32'h5;
    exc_vec = 16'h0008; int_req = 12'h800; int_en = 12'h800;
    global_ie = 1'b1;
    step();
    exc_vec = '0;
    step();
    chk("both_exc_first", 160'({trap_valid, trap_cause}),
        160'({1'b1, 32'h3}));
    step();
    step();
    chk("both_back_idle", 160'(busy), 160'd0);
    step();
    int_req = '0; global_ie = 1'b0;
    step();
    chk("both_int_later", 160'({trap_valid, trap_cause, int_ack}),
        160'({1'b1, 32'h8000_000B, 12'h800}));
    step();
    chk("both_int_redir", 160'({insert_pc, priv_pc}),
        160'({1'b1, 32'h8000_002C}));
    step();

    // ---------------- edge-triggered source 3 ----------------
    int_en = 12'h008; global_ie = 1'b0;
    int_req = 12'h008;
    step();
    int_req = '0;
    #1;
    chk("edge_latched", 160'(int_pend), 160'(12'h008));
    step();
    step();
    chk("edge_hold", 160'({int_pend, busy}), 160'({12'h008, 1'b0}));
    global_ie = 1'b1;
    step();
    global_ie = 1'b0;
    step();
    chk("edge_commit", 160'({trap_valid, trap_cause, int_ack}),
        160'({1'b1, 32'h8000_0003, 12'h008}));
    step();
    chk("edge_cleared", 160'({int_pend, insert_pc}),
        160'({12'h000, 1'b1}));
    step();
    int_req = 12'h008;
    step();
    int_req = '0;
    step();
    global_ie = 1'b1;
    step();
    global_ie = 1'b0;
    step();
    chk("edge_ack2", 160'(int_ack), 160'(12'h008));
    int_req = 12'h008;
    step();
    int_req = '0;
    #1;
    chk("edge_set_wins", 160'(int_pend), 160'(12'h008));
    step();

    // ---------------- drain hold and mid-sequence reset ----------------
    pipe_clear = 1'b0; exc_vec = 16'h0004;
    epc = 32'hA00; exc_badaddr = 32'h11;
    step();
    exc_vec = '0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_wait%0d", k),
          160'({busy, trap_valid, insert_pc}), 160'(3'b100));
      step();
    end
    pipe_clear = 1'b1;
    #1;
    chk("drain_rise", 160'(trap_valid), 160'd0);
    step();
    chk("drain_release", 160'({trap_valid, trap_cause}),
        160'({1'b1, 32'h2}));
    step();
    chk("drain_redir", 160'({insert_pc, priv_pc}),
        160'({1'b1, 32'h8000_0000}));
    step();
    pipe_clear = 1'b0; exc_vec = 16'h0004;
    step();
    exc_vec = '0;
    step();
    nRST = 1'b0;
    #1;
    chk("rst_abort", 160'(outs_now()), 160'd0);
    step();
    step();
    nRST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rst_quiet%0d", k),
          160'({busy, trap_valid, insert_pc}), 160'd0);
    end

    // ---------------- randomized vs reference model ----------------
    m_prev = '0; m_lat = '0;
    m_cause = '0; m_epc = '0; m_tval = '0;
    m_act = 0; m_drain = 0; m_ret = 0; m_tv = -1; m_ins = -1;
    for (cyc = 0; cyc < 800; cyc++) begin
      logic [NI-1:0] e_pend, e_ack, elig;
      logic [31:0]   e_pc, base;
      logic          e_tv, e_ins;
      exc_vec = ($urandom_range(0, 7) == 0) ? NE'($urandom) : '0;
      exc_badaddr = $urandom; epc = $urandom;
      if ($urandom_range(0, 3) == 0) int_req = NI'($urandom);
      if ($urandom_range(0, 7) == 0) int_en = NI'($urandom);
      global_ie = ($urandom_range(0, 3) != 0);
      mtvec = $urandom; mepc = $urandom;
      ret = ($urandom_range(0, 5) == 0);
      pipe_clear = ($urandom_range(0, 2) != 0);
      #1;
      e_pend = (int_req & ~EM) | m_lat;
      e_tv   = m_act && !m_ret && (cyc == m_tv);
      e_ins  = m_act && (cyc == m_ins);
      e_ack  = (e_tv && m_cause[31]) ? (NI'(1) << m_cause[3:0]) : '0;
      base   = {mtvec[31:2], 2'b00};
      if (!e_ins) e_pc = '0;
      else if (m_ret) e_pc = mepc;
      else if (mtvec[1:0] == 2'b01 && m_cause[31])
        e_pc = base + 4 * m_cause[30:0];
      else e_pc = base;
      chk($sformatf("rand%0d", cyc), 160'(outs_now()),
          160'({e_pend, e_tv, m_cause, m_epc, m_tval,
                e_ack, e_ins, e_pc, m_act}));
      elig = e_pend & int_en;
      if (!m_act) begin
        if (exc_vec != 0) begin
          for (int b = NE - 1; b >= 0; b--)
            if (exc_vec[b]) m_cause = 32'(b);
          m_epc = epc; m_tval = exc_badaddr;
          m_act = 1; m_drain = 1; m_ret = 0; m_tv = -1; m_ins = -1;
        end else if (global_ie && elig != 0) begin
          for (int b = 0; b < NI; b++)
            if (elig[b]) m_cause = 32'h8000_0000 | 32'(b);
          m_epc = epc; m_tval = '0;
          m_act = 1; m_drain = 1; m_ret = 0; m_tv = -1; m_ins = -1;
        end else if (ret) begin
          m_act = 1; m_drain = 0; m_ret = 1; m_tv = -1;
          m_ins = cyc + 1;
        end
      end else begin
        if (m_drain && pipe_clear) begin
          m_drain = 0; m_tv = cyc + 1; m_ins = cyc + 2;
        end
        if (cyc == m_ins) m_act = 0;
      end
      m_lat  = ((m_lat & ~e_ack) | (int_req & ~m_prev)) & EM;
      m_prev = int_req;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
